// File: rtl/hazard_stall_unit.sv
// Load-use stall and taken-branch flush control beside the ID stage, with saturating event counters.
// Define HAZARD_NOFWD_EN for datapaths without forwarding: RAW dependencies on EX/MEM also stall.
module hazard_stall_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_dx,
    input  logic [REG_ADDR_W-1:0] rt_register_dx,
    input  logic [REG_ADDR_W-1:0] rs_register_fd,
    input  logic [REG_ADDR_W-1:0] rt_register_fd,
    input  logic                  uses_rt_fd,
    input  logic                  reg_write_dx,
    input  logic [REG_ADDR_W-1:0] rd_register_dx,
    input  logic                  reg_write_xm,
    input  logic [REG_ADDR_W-1:0] rd_register_xm,
    input  logic                  branch_taken_xm,
    output logic                  pc_write,
    output logic                  fd_write,
    output logic                  fd_flush,
    output logic                  dx_bubble,
    output logic                  stall_active,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [2:0] r_flush_left;
    logic [2:0] w_flush_left_nxt;
    logic       w_lu;
    logic       w_raw;
    logic       w_flush_accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Register 0 is hardwired zero, so it can never carry a dependency.
    assign w_lu = mem_read_dx && (rt_register_dx != '0) &&
                  ((rt_register_dx == rs_register_fd) ||
                   (uses_rt_fd && (rt_register_dx == rt_register_fd)));

`ifdef HAZARD_NOFWD_EN
    logic w_rs_dep;
    logic w_rt_dep;
    assign w_rs_dep = (rs_register_fd != '0) &&
                      ((reg_write_dx && (rd_register_dx == rs_register_fd)) ||
                       (reg_write_xm && (rd_register_xm == rs_register_fd)));
    assign w_rt_dep = uses_rt_fd && (rt_register_fd != '0) &&
                      ((reg_write_dx && (rd_register_dx == rt_register_fd)) ||
                       (reg_write_xm && (rd_register_xm == rt_register_fd)));
    assign w_raw = w_rs_dep || w_rt_dep;
`else
    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{reg_write_dx, rd_register_dx, reg_write_xm, rd_register_xm};
    assign w_raw = 1'b0;
`endif

    always_comb begin
        pc_write         = 1'b1;
        fd_write         = 1'b1;
        fd_flush         = 1'b0;
        dx_bubble        = 1'b0;
        stall_active     = 1'b0;
        w_flush_accept   = 1'b0;
        w_state_nxt      = r_state;
        w_flush_left_nxt = r_flush_left;
        // Outputs hold their idle values for as long as reset is asserted.
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken_xm) begin
                        fd_flush       = 1'b1;
                        dx_bubble      = 1'b1;
                        w_flush_accept = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_flush_left_nxt = FLUSH_LOAD;
                            w_state_nxt      = ST_FLUSH;
                        end
                    end else if (w_lu || w_raw) begin
                        pc_write     = 1'b0;
                        fd_write     = 1'b0;
                        dx_bubble    = 1'b1;
                        stall_active = 1'b1;
                    end
                end
                default: begin
                    fd_flush         = 1'b1;
                    dx_bubble        = 1'b1;
                    w_flush_left_nxt = r_flush_left - 3'd1;
                    if (r_flush_left <= 3'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_flush_left <= 3'd0;
            stall_count  <= '0;
            flush_count  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_left <= w_flush_left_nxt;
            if (stall_active) begin
                stall_count <= sat_inc(stall_count);
            end
            if (w_flush_accept) begin
                flush_count <= sat_inc(flush_count);
            end
        end
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush counterpart to the pipeline forwarding path. Where forwarding cannot resolve a hazard, this block holds PC and IF/ID, inserts a bubble into ID/EX, and flushes wrong-path instructions after a taken branch resolved in MEM.
- Sits beside the ID stage of the 5-stage MIPS pipeline.
- Keeps saturating stall and flush event counters for lab performance reporting.

Parameters:
- REG_ADDR_W, 5: register-specifier width.
- CNT_W, 16: width of the stall and flush counters.
- FLUSH_CYCLES, 1: cycles of flush per taken branch. Range 1..7.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_read_dx  input  1  instruction in EX is a load.
- rt_register_dx  input  REG_ADDR_W  load destination register in EX.
- rs_register_fd  input  REG_ADDR_W  rs source of instruction in ID.
- rt_register_fd  input  REG_ADDR_W  rt source of instruction in ID.
- uses_rt_fd  input  1  instruction in ID reads rt (0 for I-type ALU, lw).
- reg_write_dx  input  1  EX instruction writes a register (used only under the macro).
- rd_register_dx  input  REG_ADDR_W  EX destination register (used only under the macro).
- reg_write_xm  input  1  MEM instruction writes a register (used only under the macro).
- rd_register_xm  input  REG_ADDR_W  MEM destination register (used only under the macro).
- branch_taken_xm  input  1  branch in MEM resolved taken.
- pc_write  output  1  PC load enable.
- fd_write  output  1  IF/ID register load enable.
- fd_flush  output  1  clear IF/ID to a nop.
- dx_bubble  output  1  zero ID/EX control signals.
- stall_active  output  1  a stall is asserted this cycle.
- stall_count  output  CNT_W  stalled cycles since reset, saturating.
- flush_count  output  CNT_W  taken-branch flush events since reset, saturating.

Behaviour:
- Reset (asynchronous):
  - state=RUN, flush counter=0, stall_count=0, flush_count=0.
  - Outputs during reset: pc_write=1, fd_write=1, fd_flush=0, dx_bubble=0, stall_active=0.
- Load-use hazard, lu = mem_read_dx && rt_register_dx!=0 && (rt_register_dx==rs_register_fd || (uses_rt_fd && rt_register_dx==rt_register_fd)).
- States:
  - RUN:
    - If branch_taken_xm: fd_flush=1, dx_bubble=1, pc_write=1, fd_write=1. If FLUSH_CYCLES>1, load the counter with FLUSH_CYCLES-1 and go to FLUSH; otherwise stay in RUN.
    - Else if lu: pc_write=0, fd_write=0, dx_bubble=1, stall_active=1; stay in RUN. The bubble clears mem_read_dx on the next cycle, so a load-use costs exactly 1 cycle.
    - Else all outputs at their reset values.
  - FLUSH:
    - fd_flush=1, dx_bubble=1, pc_write=1, fd_write=1; lu is ignored.
    - Counter decrements each cycle; at 1, go to RUN.
    - branch_taken_xm in FLUSH is ignored: those instructions are wrong-path.
- Priority: branch flush over load-use stall in the same cycle. stall_active=0 when a flush wins.
- Outputs are combinational from state and inputs; state and counters are registered.
- Counters, updated on the rising edge:
  - stall_count += 1 when stall_active=1.
  - flush_count += 1 on each branch_taken_xm accepted in RUN.
  - Both saturate at all-ones and never wrap.
- Register 0 never causes a hazard.
- Reset mid-FLUSH returns to RUN immediately; no residual flush cycles.

Optional Feature:
- Macro: HAZARD_NOFWD_EN.
- Defined (forwarding disabled in the datapath): in RUN, additionally stall (same outputs as lu) when the ID instruction reads a source register, nonzero, matching:
  - rd_register_dx with reg_write_dx=1, or
  - rd_register_xm with reg_write_xm=1.
  - rs is always a source; rt only when uses_rt_fd=1.
- The stall persists while the match holds: 2 cycles for a dependency on EX, 1 cycle for a dependency on MEM. The register file writes in the first half-cycle, so WB needs no stall.
- Not defined: reg_write_dx, rd_register_dx, reg_write_xm and rd_register_xm are ignored, and only load-use stalls occur.

Test Plan:
- Load-use: mem_read_dx=1, rt_register_dx=8, rs_register_fd=8 -> one cycle with pc_write=0, fd_write=0, dx_bubble=1; then mem_read_dx=0 -> outputs back to 1/1/0; stall_count=1.
- False hazards: rt_register_dx=0 with rs_register_fd=0, or rt match with uses_rt_fd=0 -> no stall; stall_count stays 0.
- Branch vs load: branch_taken_xm=1 together with a load-use match -> fd_flush=1, dx_bubble=1, pc_write=1, stall_active=0; flush_count=1.
- Multi-cycle flush: FLUSH_CYCLES=3, pulse branch_taken_xm -> fd_flush high exactly 3 cycles; second branch pulse in cycle 2 is ignored; flush_count=1.
- Reset mid-FLUSH: assert rst in FLUSH cycle 2 -> outputs return to reset values asynchronously, both counters=0; after release, state=RUN.
- Macro build: reg_write_dx=1, rd_register_dx=9, rs_register_fd=9, advance the pipeline -> stall 2 cycles; without the macro -> 0 stall cycles. Counter saturation (CNT_W=4, hold a stall 20 cycles) -> stall_count=15.
